// File: rtl/controlador_medicao_andar.sv
// ============================================================================
// controlador_medicao_andar
//
// Control unit for the HC-SR04 floor-measurement datapath. While `ligar` is
// high it repeats this cycle: clear, trigger, wait for the echo, register the
// reading, compare it, then wait for the interval. A floor is published on
// `andar_estavel` only after N_CONFIRMA consecutive equal readings.
// MAX_FALHAS consecutive failed measurements (timeout or out of range) latch
// `erro` until `ligar` drops.
//
// Parameters:
//   TIMEOUT     clocks allowed in ESPERA for fim_medida
//   N_CONFIRMA  consecutive identical readings needed to publish a floor
//   MAX_FALHAS  consecutive failures that force ERRO
//
// Ports:
//   clock, reset          system clock; synchronous active-high reset
//   ligar                 1 = run periodic measurement, 0 = return to idle
//   fim_medida, fim       echo finished / distance counter overflow
//   fim_loop              inter-measurement interval elapsed
//   andar[1:0]            floor decoded from the current measurement
//   zera, gera            clear datapath / start trigger pulse
//   registra, inicia_loop load distance register / enable interval counter
//   andar_estavel[1:0]    last confirmed floor
//   andar_valido          andar_estavel is valid
//   novo_andar            1-cycle pulse when a new or first floor is published
//   erro                  sensor failure latched
//   db_estado[3:0]        current state code (only with DB_ESTADO_EN defined)
//
// Optional feature: define DB_ESTADO_EN to add the db_estado debug port.
// ============================================================================
module controlador_medicao_andar #(
   parameter int unsigned TIMEOUT    = 1500000,
   parameter int unsigned N_CONFIRMA = 3,
   parameter int unsigned MAX_FALHAS = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ligar,
   input  logic       fim_medida,
   input  logic       fim,
   input  logic       fim_loop,
   input  logic [1:0] andar,
   output logic       zera,
   output logic       gera,
   output logic       registra,
   output logic       inicia_loop,
   output logic [1:0] andar_estavel,
   output logic       andar_valido,
   output logic       novo_andar,
   output logic       erro
`ifdef DB_ESTADO_EN
   ,
   output logic [3:0] db_estado
`endif
);

   localparam int unsigned TimerW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned ConfW   = $clog2(N_CONFIRMA + 1);
   localparam int unsigned FalhasW = $clog2(MAX_FALHAS + 1);

   localparam logic [TimerW-1:0]  TimerMax  = TimerW'(TIMEOUT - 1);
   localparam logic [ConfW-1:0]   ConfMax   = ConfW'(N_CONFIRMA);
   localparam logic [FalhasW-1:0] FalhasMax = FalhasW'(MAX_FALHAS);

`ifdef DB_ESTADO_EN
   typedef enum logic [3:0] {
      StInicial  = 4'd0,
      StPrepara  = 4'd1,
      StEnvia    = 4'd2,
      StEspera   = 4'd3,
      StArmazena = 4'd4,
      StCompara  = 4'd5,
      StFalha    = 4'd6,
      StAguarda  = 4'd7,
      StErro     = 4'd8
   } estado_t;
`else
   typedef enum logic [3:0] {
      StInicial,
      StPrepara,
      StEnvia,
      StEspera,
      StArmazena,
      StCompara,
      StFalha,
      StAguarda,
      StErro
   } estado_t;
`endif

   estado_t              estado;
   logic [TimerW-1:0]    timer;
   logic [1:0]           ultimo_andar;
   logic [ConfW-1:0]     conf_cnt;
   logic [FalhasW-1:0]   falhas;

   logic [ConfW-1:0]     conf_prox;
   logic [FalhasW-1:0]   falhas_prox;

   // Saturating next values used by COMPARA and FALHA.
   always_comb begin
      conf_prox   = ConfW'(1);
      falhas_prox = FalhasMax;
      if (andar == ultimo_andar) begin
         conf_prox = (conf_cnt >= ConfMax) ? ConfMax : conf_cnt + ConfW'(1);
      end
      if (falhas < FalhasMax) begin
         falhas_prox = falhas + FalhasW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado        <= StInicial;
         timer         <= '0;
         ultimo_andar  <= 2'b00;
         conf_cnt      <= '0;
         falhas        <= '0;
         zera          <= 1'b0;
         gera          <= 1'b0;
         registra      <= 1'b0;
         inicia_loop   <= 1'b0;
         andar_estavel <= 2'b00;
         andar_valido  <= 1'b0;
         novo_andar    <= 1'b0;
         erro          <= 1'b0;
      end else begin
         // Strobes are registered: each is set on the edge entering its state.
         zera        <= 1'b0;
         gera        <= 1'b0;
         registra    <= 1'b0;
         inicia_loop <= 1'b0;
         novo_andar  <= 1'b0;

         if (!ligar && (estado != StInicial)) begin
            // Stopping keeps the last published floor but drops its validity.
            estado       <= StInicial;
            andar_valido <= 1'b0;
            conf_cnt     <= '0;
            falhas       <= '0;
            erro         <= 1'b0;
         end else begin
            case (estado)
               StInicial: begin
                  if (ligar) begin
                     estado <= StPrepara;
                     zera   <= 1'b1;
                  end
               end
               StPrepara: begin
                  timer  <= '0;
                  estado <= StEnvia;
                  gera   <= 1'b1;
               end
               StEnvia: begin
                  estado <= StEspera;
               end
               StEspera: begin
                  // fim_medida has priority over a simultaneous timeout.
                  if (fim_medida) begin
                     if (fim) begin
                        estado <= StFalha;
                     end else begin
                        estado   <= StArmazena;
                        registra <= 1'b1;
                     end
                  end else if (timer == TimerMax) begin
                     estado <= StFalha;
                  end else begin
                     timer <= timer + TimerW'(1);
                  end
               end
               StArmazena: begin
                  falhas <= '0;
                  estado <= StCompara;
               end
               StCompara: begin
                  ultimo_andar <= andar;
                  conf_cnt     <= conf_prox;
                  if (conf_prox == ConfMax) begin
                     andar_estavel <= andar;
                     andar_valido  <= 1'b1;
                     novo_andar    <= !andar_valido || (andar != andar_estavel);
                  end
                  estado      <= StAguarda;
                  inicia_loop <= 1'b1;
               end
               StFalha: begin
                  falhas   <= falhas_prox;
                  conf_cnt <= '0;
                  if (falhas_prox == FalhasMax) begin
                     estado       <= StErro;
                     erro         <= 1'b1;
                     andar_valido <= 1'b0;
                  end else begin
                     estado      <= StAguarda;
                     inicia_loop <= 1'b1;
                  end
               end
               StAguarda: begin
                  if (fim_loop) begin
                     estado <= StPrepara;
                     zera   <= 1'b1;
                  end else begin
                     inicia_loop <= 1'b1;
                  end
               end
               StErro: begin
                  // Held until ligar drops.
                  estado <= StErro;
               end
               default: begin
                  estado <= StInicial;
               end
            endcase
         end
      end
   end

`ifdef DB_ESTADO_EN
   assign db_estado = estado;
`endif

endmodule

// File: tb/tb_controlador_medicao_andar.sv
// ============================================================================
// tb_controlador_medicao_andar
//
// Self-checking bench for controlador_medicao_andar (TIMEOUT=100,
// N_CONFIRMA=3, MAX_FALHAS=4). The bench acts as the sensor datapath,
// answering the strobes cycle by cycle. Expected outputs come from a
// reading-history model: a floor is confirmed when the last N_CONFIRMA
// successful readings since the last failure/stop are equal.
// ============================================================================
module tb_controlador_medicao_andar;

   localparam int unsigned TIMEOUT    = 100;
   localparam int unsigned N_CONFIRMA = 3;
   localparam int unsigned MAX_FALHAS = 4;

   localparam int KLoop     = 0;
   localparam int KReset    = 1;
   localparam int KStop     = 2;
   localparam int KResetEsp = 3;

   localparam int WInicial = 0;
   localparam int WPrepara = 1;
   localparam int WAguarda = 2;
   localparam int WErro    = 3;

   logic       clock = 1'b0;
   logic       reset;
   logic       ligar;
   logic       fim_medida;
   logic       fim;
   logic       fim_loop;
   logic [1:0] andar;
   logic       zera;
   logic       gera;
   logic       registra;
   logic       inicia_loop;
   logic [1:0] andar_estavel;
   logic       andar_valido;
   logic       novo_andar;
   logic       erro;
`ifdef DB_ESTADO_EN
   logic [3:0] db_estado;
`endif

   controlador_medicao_andar #(
      .TIMEOUT   (TIMEOUT),
      .N_CONFIRMA(N_CONFIRMA),
      .MAX_FALHAS(MAX_FALHAS)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .ligar        (ligar),
      .fim_medida   (fim_medida),
      .fim          (fim),
      .fim_loop     (fim_loop),
      .andar        (andar),
      .zera         (zera),
      .gera         (gera),
      .registra     (registra),
      .inicia_loop  (inicia_loop),
      .andar_estavel(andar_estavel),
      .andar_valido (andar_valido),
      .novo_andar   (novo_andar),
      .erro         (erro)
`ifdef DB_ESTADO_EN
      ,
      .db_estado    (db_estado)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int where  = WInicial;

   // Reference model state
   logic [1:0] m_est;
   bit         m_val;
   bit         m_err;
   int         m_falhas;
   int         m_hist[$];

   typedef struct {
      int         kind;
      int         d;
      bit         f;
      logic [1:0] a;
      logic [1:0] e_est;
      bit         e_val;
      bit         e_novo;
      bit         e_err;
   } vec_t;

   vec_t tab[$];

   function automatic vec_t mk(int k, int d, bit f, int a, int ee, bit ev, bit en, bit er);
      vec_t v;
      v.kind   = k;
      v.d      = d;
      v.f      = f;
      v.a      = 2'(a);
      v.e_est  = 2'(ee);
      v.e_val  = ev;
      v.e_novo = en;
      v.e_err  = er;
      return v;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string nome, input logic [3:0] strb, input logic nv);
      logic [8:0] act;
      logic [8:0] expv;
      act  = {zera, gera, registra, inicia_loop, andar_estavel, andar_valido, novo_andar, erro};
      expv = {strb, m_est, m_val, nv, m_err};
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s @%0t: got %b required %b (zera gera registra inicia_loop est[2] valido novo erro)",
                  nome, $time, act, expv);
      end
   endtask

   task automatic check_tab(input int idx, input vec_t v);
      logic [4:0] act;
      logic [4:0] expv;
      act  = {andar_estavel, andar_valido, novo_andar, erro};
      expv = {v.e_est, v.e_val, v.e_novo, v.e_err};
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL tabela[%0d]: got est/valido/novo/erro=%b required %b", idx, act, expv);
      end
   endtask

   task automatic model_reset();
      m_est    = 2'b00;
      m_val    = 1'b0;
      m_err    = 1'b0;
      m_falhas = 0;
      m_hist.delete();
   endtask

   task automatic model_stop();
      m_val    = 1'b0;
      m_err    = 1'b0;
      m_falhas = 0;
      m_hist.delete();
   endtask

   task automatic model_success(input logic [1:0] a, output bit nv);
      bit pub;
      int n;
      m_hist.push_back(int'(a));
      m_falhas = 0;
      n   = m_hist.size();
      pub = (n >= int'(N_CONFIRMA));
      if (pub) begin
         for (int k = 1; k < int'(N_CONFIRMA); k++) begin
            if (m_hist[n-1-k] != int'(a)) pub = 1'b0;
         end
      end
      nv = pub && (!m_val || (m_est != a));
      if (pub) begin
         m_est = a;
         m_val = 1'b1;
      end
   endtask

   task automatic model_failure();
      m_falhas++;
      m_hist.delete();
      if (m_falhas >= int'(MAX_FALHAS)) begin
         m_err = 1'b1;
         m_val = 1'b0;
      end
   endtask

   // Bring the DUT to PREPARA from INICIAL or AGUARDA.
   task automatic go_prepara(input int gap);
      if (where == WInicial) begin
         ligar = 1'b1;
         step();
         check("inicial->prepara", 4'b1000, 1'b0);
      end else if (where == WAguarda) begin
         fim_loop = 1'b0;
         for (int i = 0; i < gap; i++) begin
            step();
            check("aguarda", 4'b0001, 1'b0);
         end
         fim_loop = 1'b1;
         step();
         fim_loop = 1'b0;
         check("aguarda->prepara", 4'b1000, 1'b0);
      end
      where = WPrepara;
   endtask

   // One measurement: fim_medida at ESPERA cycle d (d >= TIMEOUT means none).
   task automatic run_loop(input int d, input bit f, input logic [1:0] a, input int gap);
      int last;
      bit nv;
      go_prepara(gap);
      andar = a;
      step();
      check("envia", 4'b0100, 1'b0);
      step();
      last = (d < int'(TIMEOUT)) ? d : int'(TIMEOUT) - 1;
      for (int i = 0; i <= last; i++) begin
         check("espera", 4'b0000, 1'b0);
         if (i == d) begin
            fim_medida = 1'b1;
            fim        = f;
         end
         step();
         fim_medida = 1'b0;
         fim        = 1'b0;
      end
      if ((d < int'(TIMEOUT)) && !f) begin
         check("armazena", 4'b0010, 1'b0);
         step();
         check("compara", 4'b0000, 1'b0);
         model_success(a, nv);
         step();
         check("aguarda pos-compara", 4'b0001, nv);
         where = WAguarda;
      end else begin
         check("falha", 4'b0000, 1'b0);
         model_failure();
         step();
         if (m_err) begin
            check("erro", 4'b0000, 1'b0);
            where = WErro;
         end else begin
            check("falha->aguarda", 4'b0001, 1'b0);
            where = WAguarda;
         end
      end
   endtask

   task automatic do_stop();
      if (where == WErro) begin
         for (int i = 0; i < 3; i++) begin
            step();
            check("erro retido", 4'b0000, 1'b0);
         end
      end
      ligar = 1'b0;
      step();
      model_stop();
      check("parada", 4'b0000, 1'b0);
      step();
      check("parada ociosa", 4'b0000, 1'b0);
      where = WInicial;
   endtask

   // ligar is left as-is on the reset edge so a dead reset cannot hide.
   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      ligar = 1'b0;
      model_reset();
      check("reset", 4'b0000, 1'b0);
      step();
      check("reset ocioso", 4'b0000, 1'b0);
      where = WInicial;
   endtask

   task automatic reset_in_espera();
      go_prepara(1);
      step();
      check("envia", 4'b0100, 1'b0);
      for (int i = 0; i < 7; i++) begin
         step();
         check("espera", 4'b0000, 1'b0);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_reset();
      check("reset em espera", 4'b0000, 1'b0);
      where = WInicial;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] prev;
      int r;
      int sel;
      int d;
      bit f;
      logic [1:0] a;

      reset      = 1'b1;
      ligar      = 1'b0;
      fim_medida = 1'b0;
      fim        = 1'b0;
      fim_loop   = 1'b0;
      andar      = 2'b00;
      model_reset();
      step();
      step();
      reset = 1'b0;

      // kind, d, fim, andar, expected est, valido, novo, erro
      tab.push_back(mk(KReset,    0,   0, 0, 0, 0, 0, 0));
      tab.push_back(mk(KLoop,     20,  0, 2, 0, 0, 0, 0));
      tab.push_back(mk(KLoop,     20,  0, 2, 0, 0, 0, 0));
      tab.push_back(mk(KLoop,     20,  0, 2, 2, 1, 1, 0));
      tab.push_back(mk(KReset,    0,   0, 0, 0, 0, 0, 0));
      tab.push_back(mk(KLoop,     15,  0, 1, 0, 0, 0, 0));
      tab.push_back(mk(KLoop,     15,  0, 1, 0, 0, 0, 0));
      tab.push_back(mk(KLoop,     30,  0, 2, 0, 0, 0, 0));
      tab.push_back(mk(KLoop,     0,   0, 2, 0, 0, 0, 0));
      tab.push_back(mk(KLoop,     20,  0, 2, 2, 1, 1, 0));
      tab.push_back(mk(KLoop,     99,  0, 3, 2, 1, 0, 0));
      tab.push_back(mk(KLoop,     5,   1, 3, 2, 1, 0, 0));
      tab.push_back(mk(KLoop,     10,  0, 3, 2, 1, 0, 0));
      tab.push_back(mk(KLoop,     100, 0, 3, 2, 1, 0, 0));
      tab.push_back(mk(KLoop,     100, 0, 3, 2, 1, 0, 0));
      tab.push_back(mk(KLoop,     100, 0, 3, 2, 1, 0, 0));
      tab.push_back(mk(KLoop,     100, 0, 3, 2, 0, 0, 1));
      tab.push_back(mk(KStop,     0,   0, 0, 0, 0, 0, 0));
      tab.push_back(mk(KLoop,     20,  0, 3, 2, 0, 0, 0));
      tab.push_back(mk(KLoop,     20,  0, 3, 2, 0, 0, 0));
      tab.push_back(mk(KLoop,     20,  0, 3, 3, 1, 1, 0));
      tab.push_back(mk(KStop,     0,   0, 0, 0, 0, 0, 0));
      tab.push_back(mk(KLoop,     20,  0, 3, 3, 0, 0, 0));
      tab.push_back(mk(KLoop,     20,  0, 3, 3, 0, 0, 0));
      tab.push_back(mk(KLoop,     20,  0, 3, 3, 1, 1, 0));
      tab.push_back(mk(KResetEsp, 0,   0, 0, 0, 0, 0, 0));
      tab.push_back(mk(KLoop,     12,  0, 1, 0, 0, 0, 0));
      tab.push_back(mk(KLoop,     12,  0, 1, 0, 0, 0, 0));
      tab.push_back(mk(KLoop,     12,  0, 1, 1, 1, 1, 0));
      tab.push_back(mk(KReset,    0,   0, 0, 0, 0, 0, 0));

      foreach (tab[i]) begin
         case (tab[i].kind)
            KLoop: begin
               run_loop(tab[i].d, tab[i].f, tab[i].a, 2);
               check_tab(i, tab[i]);
            end
            KReset:    do_reset();
            KStop:     do_stop();
            KResetEsp: reset_in_espera();
            default:   ;
         endcase
      end

      // Randomized loops against the model
      prev = 2'b00;
      for (int n = 0; n < 120; n++) begin
         r = $urandom_range(0, 99);
         if ((where == WErro) || (r < 4)) begin
            do_stop();
         end else if (r < 6) begin
            do_reset();
         end else begin
            sel = $urandom_range(0, 19);
            f   = 1'b0;
            if (sel < 14) begin
               d = $urandom_range(0, 40);
            end else if (sel < 16) begin
               d = $urandom_range(95, 99);
            end else if (sel < 18) begin
               d = int'(TIMEOUT);
            end else begin
               d = $urandom_range(0, 40);
               f = 1'b1;
            end
            a    = ($urandom_range(0, 3) < 3) ? prev : 2'($urandom_range(0, 3));
            prev = a;
            run_loop(d, f, a, $urandom_range(0, 4));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/controlador_medicao_andar.md
Name: controlador_medicao_andar

Overview:
- Control unit that sequences the HC-SR04 interface datapath through repeated trigger, measure, register and wait cycles.
- Drives the datapath strobes `zera`, `gera`, `registra` and `inicia_loop`.
- Supervises echo timeouts and out-of-range readings, and publishes a debounced floor (`andar_estavel`) only after N_CONFIRMA consecutive equal readings.
- Sits between the PoLift top-level elevator FSM and the sensor datapath.

Parameters:
- TIMEOUT, 1500000: clocks allowed in ESPERA for `fim_medida` (30 ms at 50 MHz).
- N_CONFIRMA, 3: consecutive identical floor readings required to publish.
- MAX_FALHAS, 4: consecutive failed measurements that force ERRO.

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- ligar  in  1  level; 1 = run periodic measurement, 0 = return to INICIAL
- fim_medida  in  1  datapath: echo measurement finished
- fim  in  1  datapath: distance counter overflow (out of range)
- fim_loop  in  1  datapath: inter-measurement interval elapsed
- andar  in  2  datapath: floor decoded from current measurement
- zera  out  1  clears datapath counters, register and loop counter
- gera  out  1  starts the 10 us trigger pulse
- registra  out  1  loads the distance register
- inicia_loop  out  1  enables the interval counter
- andar_estavel  out  2  last confirmed floor
- andar_valido  out  1  andar_estavel is valid
- novo_andar  out  1  1-cycle pulse when andar_estavel is updated to a different value or first becomes valid
- erro  out  1  sensor failure latched

Behaviour:
- **Reset (synchronous)**
  - State goes to INICIAL.
  - All outputs are 0; andar_estavel = 2'b00.
  - Internal ultimo_andar = 0, conf_cnt = 0, falhas = 0, timer = 0.
- **States and transitions** (Moore strobes, asserted during the state):
  - INICIAL(0): all strobes 0. Go to PREPARA if ligar = 1.
  - PREPARA(1): zera = 1; timer <= 0. Go to ENVIA.
  - ENVIA(2): gera = 1. Go to ESPERA.
  - ESPERA(3): timer increments each cycle.
    - fim_medida = 1 and fim = 0: go to ARMAZENA.
    - fim_medida = 1 and fim = 1: failure (out of range); go to FALHA.
    - timer == TIMEOUT-1 without fim_medida: go to FALHA.
    - fim_medida and the timeout in the same cycle: fim_medida wins.
  - ARMAZENA(4): registra = 1; falhas <= 0. Go to COMPARA.
  - COMPARA(5):
    - If andar == ultimo_andar, conf_cnt <= min(conf_cnt+1, N_CONFIRMA).
    - Otherwise ultimo_andar <= andar and conf_cnt <= 1.
    - When the new conf_cnt equals N_CONFIRMA: andar_estavel <= ultimo_andar (the updated value) and andar_valido <= 1.
    - novo_andar pulses in the following cycle only if the value changed or andar_valido was 0.
    - Go to AGUARDA.
  - FALHA(6): falhas <= falhas+1 (saturating); conf_cnt <= 0.
    - If falhas+1 == MAX_FALHAS: go to ERRO.
    - Otherwise go to AGUARDA.
    - andar_estavel and andar_valido are retained.
  - AGUARDA(7): inicia_loop = 1. Go to PREPARA when fim_loop = 1.
  - ERRO(8): erro = 1; andar_valido = 0; all strobes 0. Stays in ERRO until ligar = 0.
- **ligar = 0** in any state other than INICIAL:
  - Next state is INICIAL.
  - andar_valido <= 0, conf_cnt <= 0, falhas <= 0, erro <= 0.
  - andar_estavel keeps its value.
- **Latency**
  - ligar rising in INICIAL → zera at cycle 1, gera at cycle 2.
  - fim_medida → registra 1 cycle later.
  - First publication needs N_CONFIRMA full loops.
- **Counter widths**
  - timer is $clog2(TIMEOUT) bits.
  - conf_cnt and falhas are $clog2(max+1) bits.
  - Wrap-around is impossible because both saturate.
- Only one strobe is asserted per cycle.

Optional Feature:
- Macro DB_ESTADO_EN.
- Defined: adds output port db_estado [3:0] carrying the current state encoding above (for 7-segment debug on the board).
- Undefined: the port does not exist and state encoding is left to synthesis.

Test Plan:
- Parameters for all scenarios: TIMEOUT = 100, N_CONFIRMA = 3, MAX_FALHAS = 4.
- **Normal confirmation:** ligar = 1, three loops with fim_medida after 20 cycles, andar = 2.
  - zera, gera and registra each pulse once per loop.
  - andar_valido = 1 and andar_estavel = 2 after the 3rd COMPARA.
  - novo_andar pulses once.
- **Disagreement:** andar sequence 1, 1, 2, 2, 2.
  - No publication after the first two readings.
  - andar_estavel = 2 after the 5th reading.
  - conf_cnt restarts at the 3rd reading.
- **Timeout:** no fim_medida.
  - FALHA after exactly 100 cycles in ESPERA.
  - After 4 consecutive timeouts, erro = 1 and andar_valido = 0.
  - ligar = 0 then 1 clears erro and restarts at PREPARA.
- **Out of range and tie:**
  - fim_medida together with fim → counted as a failure; registra not asserted.
  - fim_medida in the same cycle as timer == 99 → ARMAZENA taken.
- **Reset mid-operation:** reset in ESPERA and in AGUARDA.
  - Next cycle: state INICIAL, all outputs 0, andar_estavel = 0.
- **Stop during operation:** ligar = 0 during AGUARDA with andar_estavel = 3 valid.
  - INICIAL next cycle; andar_valido = 0; andar_estavel stays 3.
  - Re-arming needs 3 new matching readings.
